// File: rtl/dot_prod_pkg.sv
// Shared widths, Q-format constants and the scale/limit helper for the
// dot_prod matrix-vector datapath.
// Build option: DOT_PROD_SATURATE_EN selects clamping of each scaled row sum
// to the signed result range; left undefined, the result wraps (low bits kept).
package dot_prod_pkg;

    // Working width of the scale/limit helper, wide enough for any accumulator
    localparam int SATW = 64;

    // Default Q-format fractional bits and the value 1.0 in that format
    localparam int QM_DEFAULT = 11;
    localparam int ONE        = 1 << QM_DEFAULT;

    // Flags that travel alongside each column of data through the pipeline
    typedef struct packed {
        logic valid;
        logic last;
    } pipeFlags_t;

    function automatic int bitWidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int addrWidth(input int ncol);
        return (ncol > 1) ? $clog2(ncol) : 1;
    endfunction

    function automatic int accWidth(input int bw, input int ncol);
        return 2 * bw + $clog2(ncol);
    endfunction

    function automatic int qOne(input int qm);
        return 1 << qm;
    endfunction

    // Reduce a sign-extended scaled sum to bw bits: clamp or wrap
    function automatic logic signed [SATW-1:0] sat_trunc(
        input logic signed [SATW-1:0] val,
        input int                     bw
    );
`ifdef DOT_PROD_SATURATE_EN
        logic signed [SATW-1:0] maxV;
        logic signed [SATW-1:0] minV;
        maxV = (64'sd1 <<< (bw - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (bw - 1));
        if (val > maxV) begin
            return maxV;
        end else if (val < minV) begin
            return minV;
        end
        return val;
`else
        logic signed [SATW-1:0] mask;
        mask = (64'sd1 <<< bw) - 64'sd1;
        return val & mask;
`endif
    endfunction

endpackage

// File: rtl/dot_prod_mac.sv
// One row lane of the dot product: a pipelined signed multiplier feeding an
// accumulator whose pass result is scaled back to Q format and latched.
// Build option: DOT_PROD_SATURATE_EN (through sat_trunc) clamps instead of wraps.
module dot_prod_mac
    import dot_prod_pkg::*;
#(
    parameter int BITWIDTH = 18,
    parameter int ACCW     = 39,
    parameter int QM       = 11,
    parameter int PIPE     = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] weight_i,
    input  logic [BITWIDTH-1:0] x_i,
    input  logic                accEn_i,
    input  logic                accFirst_i,
    input  logic                accLast_i,
    output logic [BITWIDTH-1:0] result_o
);

    localparam int PW = 2 * BITWIDTH;

    logic signed [PW-1:0]       weightExt;
    logic signed [PW-1:0]       xExt;
    logic signed [PW-1:0]       prod_d;
    logic [PIPE-1:0][PW-1:0]    prodPipe_q;
    logic signed [ACCW-1:0]     prodAcc;
    logic signed [ACCW-1:0]     acc_q;
    logic signed [ACCW-1:0]     acc_d;
    logic signed [ACCW-1:0]     shifted;
    logic [BITWIDTH-1:0]        result_q;
    logic [BITWIDTH-1:0]        result_d;

    // Full-precision signed product of the weight and the input element
    always_comb begin
        weightExt = PW'($signed(weight_i));
        xExt      = PW'($signed(x_i));
        prod_d    = weightExt * xExt;
    end

    // Multiplier output register chain; cleared so a reset drops in-flight products
    always_ff @(posedge clock) begin
        if (reset) begin
            prodPipe_q <= '0;
        end else begin
            prodPipe_q[0] <= prod_d;
            for (int k = 1; k < PIPE; k++) begin
                prodPipe_q[k] <= prodPipe_q[k-1];
            end
        end
    end

    // First column of a pass loads the accumulator; scaling happens after the full sum
    always_comb begin
        prodAcc  = ACCW'($signed(prodPipe_q[PIPE-1]));
        acc_d    = accFirst_i ? prodAcc : acc_q + prodAcc;
        shifted  = acc_d >>> QM;
        result_d = BITWIDTH'(sat_trunc(SATW'(shifted), BITWIDTH));
    end

    // Accumulate on valid columns and hold the scaled result until the next pass ends
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
        end else if (accEn_i) begin
            acc_q <= acc_d;
            if (accLast_i) begin
                result_q <= result_d;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/dot_prod.sv
// Streaming fixed-point matrix-vector product y = W*x. Drives the column
// address of an external weight RAM every cycle, tracks each column through
// the multiplier pipeline, and publishes all rows with a one-cycle dataReady.
// Build option: DOT_PROD_SATURATE_EN clamps row results instead of wrapping.
module dot_prod
    import dot_prod_pkg::*;
#(
    parameter int  NROW          = 16,
    parameter int  NCOL          = 8,
    parameter int  QN            = 6,
    parameter int  QM            = 11,
    parameter int  DSP48_PER_ROW = 2,
    localparam int BITWIDTH      = bitWidth(QN, QM),
    localparam int ADDR_BITWIDTH = addrWidth(NCOL)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NROW*BITWIDTH-1:0] weightMemOutput,
    input  logic [BITWIDTH-1:0]      inputVec,
    output logic                     dataReady,
    output logic [ADDR_BITWIDTH-1:0] colAddress,
    output logic [NROW*BITWIDTH-1:0] outputVec
);

    localparam int ACCW  = accWidth(BITWIDTH, NCOL);
    localparam int DEPTH = DSP48_PER_ROW + 1;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

    logic [ADDR_BITWIDTH-1:0]             colAddr_q;
    logic [ADDR_BITWIDTH-1:0]             colAddr_d;
    pipeFlags_t                           stage0;
    pipeFlags_t [DEPTH-1:0]               flags_q;
    logic [DEPTH-1:0][ADDR_BITWIDTH-1:0]  colIdx_q;
    logic                                 dataReady_q;
    logic                                 dataReady_d;
    logic                                 accEn;
    logic                                 accFirst;
    logic                                 accLast;

    // Next column address wraps to zero with no idle cycle between passes
    always_comb begin
        colAddr_d = (colAddr_q == LAST_COL) ? '0 : colAddr_q + ADDR_BITWIDTH'(1);
    end

    // Column address counter, runs continuously once out of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            colAddr_q <= '0;
        end else begin
            colAddr_q <= colAddr_d;
        end
    end

    // Tag for the column whose RAM word arrives next cycle, plus lane controls at the accumulate stage
    always_comb begin
        stage0.valid = 1'b1;
        stage0.last  = (colAddr_q == LAST_COL);
        accEn        = flags_q[DEPTH-1].valid;
        accLast      = flags_q[DEPTH-1].last;
        accFirst     = (colIdx_q[DEPTH-1] == '0);
        dataReady_d  = accEn & accLast;
    end

    // Valid/last/column shift register kept in step with the multiplier pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q  <= '0;
            colIdx_q <= '0;
        end else begin
            flags_q[0]  <= stage0;
            colIdx_q[0] <= colAddr_q;
            for (int k = 1; k < DEPTH; k++) begin
                flags_q[k]  <= flags_q[k-1];
                colIdx_q[k] <= colIdx_q[k-1];
            end
        end
    end

    // Completion pulse registered alongside the row results
    always_ff @(posedge clock) begin
        if (reset) begin
            dataReady_q <= 1'b0;
        end else begin
            dataReady_q <= dataReady_d;
        end
    end

    for (genvar r = 0; r < NROW; r++) begin : gRow
        dot_prod_mac #(
            .BITWIDTH (BITWIDTH),
            .ACCW     (ACCW),
            .QM       (QM),
            .PIPE     (DSP48_PER_ROW)
        ) uMac (
            .clock      (clock),
            .reset      (reset),
            .weight_i   (weightMemOutput[r*BITWIDTH +: BITWIDTH]),
            .x_i        (inputVec),
            .accEn_i    (accEn),
            .accFirst_i (accFirst),
            .accLast_i  (accLast),
            .result_o   (outputVec[r*BITWIDTH +: BITWIDTH])
        );
    end

    assign colAddress = colAddr_q;
    assign dataReady  = dataReady_q;

endmodule

// File: tb/tb_dot_prod.sv
// Directed testbench for dot_prod at default parameters. A behavioural
// stand-in for weight_ram (one-cycle read, cleared by reset) supplies the
// weight column and the paired x element; expected row values are hand-computed.
// Build option: DOT_PROD_SATURATE_EN changes the expected overflow results.
module tb_dot_prod;

    localparam int NROW = 16;
    localparam int NCOL = 8;
    localparam int BW   = 18;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NROW*BW-1:0]   weightMemOutput;
    logic [BW-1:0]        inputVec;
    logic                 dataReady;
    logic [2:0]           colAddress;
    logic [NROW*BW-1:0]   outputVec;

    logic [BW-1:0]        wMem [NROW][NCOL];
    logic [BW-1:0]        xMem [NCOL];

    int checkCount = 0;
    int errorCount = 0;

    always #5 clock = ~clock;

    dot_prod dut (
        .clock           (clock),
        .reset           (reset),
        .weightMemOutput (weightMemOutput),
        .inputVec        (inputVec),
        .dataReady       (dataReady),
        .colAddress      (colAddress),
        .outputVec       (outputVec)
    );

    // Synchronous weight/x memory: the word for colAddress appears one cycle later
    always @(posedge clock) begin
        if (reset) begin
            weightMemOutput <= '0;
            inputVec        <= '0;
        end else begin
            for (int r = 0; r < NROW; r++) begin
                weightMemOutput[r*BW +: BW] <= wMem[r][colAddress];
            end
            inputVec <= xMem[colAddress];
        end
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hand-computed row results per scenario
    function automatic logic [BW-1:0] expRow(input int scen, input int r);
        case (scen)
            0: return 18'd16384;
            1: return 18'h3C000;
            2: return 18'd4;
`ifdef DOT_PROD_SATURATE_EN
            3: return 18'h1FFFF;
            4: return 18'h20000;
`else
            3: return 18'h04000;
            4: return 18'h3C000;
`endif
            5: return 18'd73728;
            6: return 18'd36864;
            7: return 18'(r * 2048);
            default: return 18'd0;
        endcase
    endfunction

    // Load memories for a scenario under reset, then release reset
    task automatic applyStimulus(input int scen);
        @(negedge clock);
        reset = 1'b1;
        for (int j = 0; j < NCOL; j++) begin
            case (scen)
                0, 7:    xMem[j] = 18'd2048;
                1:       xMem[j] = 18'd2048;
                2:       xMem[j] = 18'd1;
                3:       xMem[j] = 18'd63488;
                4:       xMem[j] = 18'(-63488);
                5:       xMem[j] = 18'((j + 1) * 2048);
                6:       xMem[j] = 18'((j + 1) * 1024);
                default: xMem[j] = 18'd0;
            endcase
            for (int r = 0; r < NROW; r++) begin
                case (scen)
                    1:       wMem[r][j] = 18'(-2048);
                    2:       wMem[r][j] = 18'd1024;
                    3, 4:    wMem[r][j] = 18'd63488;
                    7:       wMem[r][j] = 18'(r * 256);
                    default: wMem[r][j] = 18'd2048;
                endcase
            end
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Wait for dataReady, reporting cycles since the preceding colAddress==7
    task automatic waitReady(output logic found, output int latency);
        int since;
        found   = 1'b0;
        latency = -1;
        since   = -1;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clock);
            if (since >= 0) since++;
            if (dataReady) begin
                found   = 1'b1;
                latency = since;
            end else if (colAddress == 3'd7) begin
                since = 0;
            end
        end
    endtask

    task automatic checkRows(input string tag, input int scen);
        for (int r = 0; r < NROW; r++) begin
            checkOutput($sformatf("%s_row%0d", tag, r),
                        64'(outputVec[r*BW +: BW]), 64'(expRow(scen, r)));
        end
    endtask

    task automatic runScenario(input int scen, input string tag);
        logic found;
        int   latency;
        applyStimulus(scen);
        waitReady(found, latency);
        checkOutput({tag, "_ready"}, 64'(found), 64'd1);
        checkOutput({tag, "_latency"}, 64'(latency), 64'd4);
        checkRows(tag, scen);
    endtask

    initial begin
        logic found;
        int   latency;
        int   period;
        logic seenFour;

        $display("[TB] dot_prod directed test start");
        applyStimulus(0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("rst_colAddress", 64'(colAddress), 64'd0);
        checkOutput("rst_dataReady", 64'(dataReady), 64'd0);
        checkOutput("rst_outputZero", 64'(|outputVec), 64'd0);
        reset = 1'b0;

        waitReady(found, latency);
        checkOutput("allOnes_ready", 64'(found), 64'd1);
        checkOutput("allOnes_latency", 64'(latency), 64'd4);
        checkRows("allOnes", 0);

        @(negedge clock);
        checkOutput("pulseWidth", 64'(dataReady), 64'd0);
        checkOutput("holdRow3", 64'(outputVec[3*BW +: BW]), 64'd16384);
        period = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            period++;
            if (dataReady) break;
        end
        checkOutput("period", 64'(period), 64'd8);
        checkRows("steady", 0);

        seenFour = 1'b0;
        for (int c = 0; c < 20 && !seenFour; c++) begin
            @(negedge clock);
            if (colAddress == 3'd4) seenFour = 1'b1;
        end
        checkOutput("midReset_seenCol4", 64'(seenFour), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midReset_colAddress", 64'(colAddress), 64'd0);
        checkOutput("midReset_outputZero", 64'(|outputVec), 64'd0);
        checkOutput("midReset_dataReady", 64'(dataReady), 64'd0);
        reset = 1'b0;
        waitReady(found, latency);
        checkOutput("midReset_ready", 64'(found), 64'd1);
        checkOutput("midReset_latency", 64'(latency), 64'd4);
        checkRows("midReset", 0);

        runScenario(1, "negOnes");
        runScenario(2, "smallLsb");
        runScenario(3, "bigPos");
        runScenario(4, "bigNeg");
        runScenario(5, "xStep1");
        runScenario(6, "xStepHalf");
        runScenario(7, "rowRamp");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
